// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, redirect and data-memory-wait sequencing for the 5-stage MIPS pipeline
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_branch_i,
  input  logic             ex_zero_i,
  input  logic             id_jump_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             memwb_bubble_o,
  output logic             dmem_req_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic {RUN, MEM_WAIT} state_e;
  state_e           state_q;
  logic [WW-1:0]    wcnt_q;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic wait_s, limit, rel, frozen, br_d, jmp_d, lu_hit, lu_d;
  // Event decode: a frozen memory access outranks the taken branch, which outranks jump, which outranks load-use
  always_comb begin
    wait_s = state_q == MEM_WAIT;
    limit  = wcnt_q == WW'(WAIT_MAX);
    rel    = wait_s && (dmem_ready_i || limit);
    frozen = wait_s ? !rel : (mem_access_i && !dmem_ready_i);
    br_d   = ex_branch_i && ex_zero_i && !frozen;
    jmp_d  = id_jump_i && !br_d && !frozen;
    lu_hit = ex_memread_i && ex_rt_i != 5'd0 &&
             ((ex_rt_i == id_rs_i && id_opcode_i != 6'd2) ||
              (ex_rt_i == id_rt_i && (id_opcode_i == 6'd0 || id_opcode_i == 6'd4 || id_opcode_i == 6'd43)));
    lu_d   = lu_hit && !br_d && !jmp_d && !frozen;
  end
  // Pipeline controls, all forced low while reset is held
  always_comb begin
    pc_write_o     = rst_n && !frozen && !lu_d;
    ifid_write_o   = rst_n && !frozen && !lu_d && !br_d && !jmp_d ? 1'b1 : rst_n && (br_d || jmp_d);
    ifid_flush_o   = rst_n && (br_d || jmp_d);
    idex_bubble_o  = rst_n && (br_d || lu_d);
    pipe_hold_o    = rst_n && frozen;
    memwb_bubble_o = rst_n && frozen;
    dmem_req_o     = rst_n && (wait_s || mem_access_i);
    mem_timeout_o  = timeout_q;
    stall_cnt_o    = stall_q;
    flush_cnt_o    = flush_q;
  end
  // Wait FSM, sticky timeout flag and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= frozen ? MEM_WAIT : RUN;
      wcnt_q    <= frozen ? wcnt_q + 1'b1 : '0;
      timeout_q <= timeout_q || (wait_s && !dmem_ready_i && limit);
      if ((frozen || lu_d) && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if ((br_d || jmp_d) && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard checked by a separate monitor
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_memread = 0, ex_branch = 0, ex_zero = 0, id_jump = 0, mem_access = 0, dmem_ready = 0;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, dmem_req, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pcw, s_ifw, s_fl, s_bub, s_hold, s_mwb, s_req, s_tmo;
  logic [1:0] s_stall, s_flush;
  int n_cmp = 0, n_bad = 0;
  string nq[$];
  logic [7:0] cq[$];
  int sq[$], fq[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .WAIT_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_opcode_i(id_opcode), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .ex_branch_i(ex_branch), .ex_zero_i(ex_zero),
    .id_jump_i(id_jump), .mem_access_i(mem_access), .dmem_ready_i(dmem_ready),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .pipe_hold_o(pipe_hold), .memwb_bubble_o(memwb_bubble),
    .dmem_req_o(dmem_req), .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

  pipe_hazard_ctrl #(.CNT_W(2), .WAIT_MAX(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_opcode_i(id_opcode), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .ex_branch_i(ex_branch), .ex_zero_i(ex_zero),
    .id_jump_i(id_jump), .mem_access_i(mem_access), .dmem_ready_i(dmem_ready),
    .pc_write_o(s_pcw), .ifid_write_o(s_ifw), .ifid_flush_o(s_fl),
    .idex_bubble_o(s_bub), .pipe_hold_o(s_hold), .memwb_bubble_o(s_mwb),
    .dmem_req_o(s_req), .mem_timeout_o(s_tmo), .stall_cnt_o(s_stall), .flush_cnt_o(s_flush));

  // c = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, dmem_req, mem_timeout}
  task automatic step(input string nm, input logic rn, input logic [5:0] opc, input logic [4:0] rs, rt,
                      input logic mr, input logic [4:0] ert, input logic br, z, j, ma, rdy,
                      input logic [7:0] c, input int s, f);
    @(posedge clk);
    #1;
    rst_n = rn; id_opcode = opc; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = ert;
    ex_branch = br; ex_zero = z; id_jump = j; mem_access = ma; dmem_ready = rdy;
    nq.push_back(nm); cq.push_back(c); sq.push_back(s); fq.push_back(f);
  endtask

  always @(negedge clk) begin
    if (cq.size() > 0) begin
      string nm;
      logic [7:0] c, act;
      int s, f, sat;
      nm = nq.pop_front(); c = cq.pop_front(); s = sq.pop_front(); f = fq.pop_front();
      sat = s > 3 ? 3 : s;
      act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, dmem_req, mem_timeout};
      n_cmp += 4;
      if (act !== c) begin
        n_bad++;
        $display("FAIL %s ctrl: got %b want %b", nm, act, c);
      end
      if (stall_cnt !== 16'(s)) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, s);
      end
      if (flush_cnt !== 16'(f)) begin
        n_bad++;
        $display("FAIL %s flush_cnt: got %0d want %0d", nm, flush_cnt, f);
      end
      if (s_stall !== 2'(sat)) begin
        n_bad++;
        $display("FAIL %s sat_stall_cnt: got %0d want %0d", nm, s_stall, sat);
      end
    end
  end

  initial begin
    //     name        rn opc rs rt mr ert br z  j  ma rdy ctrl          S   F
    step("reset",     0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0,  0);
    step("idle",      1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 0,  0);
    step("lu_rt",     1, 0,  0, 8, 1, 8, 0, 0, 0, 0, 0, 8'b0001_0000, 0,  0);
    step("after_lu",  1, 0,  0, 8, 0, 8, 0, 0, 0, 0, 0, 8'b1100_0000, 1,  0);
    step("rt_zero",   1, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 1,  0);
    step("opc9",      1, 9,  3, 8, 1, 8, 0, 0, 0, 0, 0, 8'b1100_0000, 1,  0);
    step("lu_rs",     1, 35, 9, 4, 1, 9, 0, 0, 0, 0, 0, 8'b0001_0000, 1,  0);
    step("rs_jop",    1, 2,  9, 4, 1, 9, 0, 0, 0, 0, 0, 8'b1100_0000, 2,  0);
    step("branch",    1, 0,  0, 8, 1, 8, 1, 1, 1, 0, 0, 8'b1111_0000, 2,  0);
    step("jump",      1, 0,  0, 8, 1, 8, 1, 0, 1, 0, 0, 8'b1110_0000, 2,  1);
    step("idle2",     1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 2,  2);
    step("freeze",    1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 2,  2);
    step("wait1",     1, 0,  0, 8, 1, 8, 1, 1, 1, 1, 0, 8'b0000_1110, 3,  2);
    step("wait2",     1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 4,  2);
    step("release",   1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b1100_0010, 5,  2);
    step("zero_wait", 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b1100_0010, 5,  2);
    step("idle3",     1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 5,  2);
    step("to_freeze", 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 5,  2);
    step("to_w1",     1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 6,  2);
    step("to_w2",     1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 7,  2);
    step("to_w3",     1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1110, 8,  2);
    step("to_rel",    1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b1100_0010, 9,  2);
    step("tmo_set",   1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0001, 9,  2);
    step("tmo_stay",  1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0001, 9,  2);
    step("freeze2",   1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1111, 9,  2);
    step("wait_b",    1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_1111, 10, 2);
    step("rst_mid",   0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_0000, 0,  0);
    step("post_rst",  1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 0,  0);
    step("lu_again",  1, 4,  0, 8, 1, 8, 0, 0, 0, 0, 0, 8'b0001_0000, 0,  0);
    step("final",     1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000, 1,  0);
    for (int i = 0; i < 8 && cq.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (cq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
